// File: rtl/csr_uart_rx_fifo.sv
// rtl/csr_uart_rx_fifo.sv - CSR-mapped 8N1 UART receiver with an 8-bit receive FIFO and irq.
module csr_uart_rx_fifo #(
    parameter logic [11:0] BASE_ADDR  = 12'hbc3,
    parameter int          CLOCK_RATE = 12_000_000,
    parameter int          BAUD_RATE  = 115200,
    parameter int          DEPTH_LOG2 = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        read,
    input  logic [2:0]  modify,
    input  logic [31:0] wdata,
    input  logic [11:0] addr,
    output logic [31:0] rdata,
    output logic        valid,
    input  logic        rx,
    output logic        irq
);

    localparam int                    DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [15:0]           CLOCK_DIV = 16'(CLOCK_RATE / BAUD_RATE);
    localparam logic [15:0]           HALF_DIV  = 16'(CLOCK_RATE / BAUD_RATE / 2);
    localparam logic [DEPTH_LOG2:0]   DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = (DEPTH_LOG2)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t state, state_nxt;

    logic                  rx_meta, rxs;
    logic [15:0]           baud_cnt;
    logic [2:0]            bit_idx;
    logic [7:0]            shreg;
    logic                  tick;
    logic                  load_half, load_full, cnt_dec, shift_en, clr_idx;
    logic                  push_req, ferr_set;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  ovr, ferr;
    logic                  csr_hit, csr_wr, pop_req, flush, fifo_empty, pop_ok, push_ok;
    logic [31:0]           rd_word;
    logic                  unused_bits;

    assign unused_bits = ^{read, wdata[31:11], wdata[8:2]};

    // rx is asynchronous; only rxs may feed the receiver logic
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    assign tick = (baud_cnt == 16'd0);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (!rxs) state_nxt = S_START;
            S_START:     if (tick) state_nxt = rxs ? S_IDLE : S_DATA;
            S_DATA:      if (tick && bit_idx == 3'd7) state_nxt = S_STOP;
            S_STOP:      if (tick) state_nxt = rxs ? S_IDLE : S_WAIT_HIGH;
            S_WAIT_HIGH: if (rxs) state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        load_half = 1'b0;
        load_full = 1'b0;
        cnt_dec   = 1'b0;
        shift_en  = 1'b0;
        clr_idx   = 1'b0;
        push_req  = 1'b0;
        ferr_set  = 1'b0;
        case (state)
            S_IDLE: load_half = !rxs;
            S_START: begin
                if (!tick)     cnt_dec = 1'b1;
                else if (!rxs) begin
                    load_full = 1'b1;
                    clr_idx   = 1'b1;
                end
            end
            S_DATA: begin
                if (!tick) cnt_dec = 1'b1;
                else begin
                    shift_en  = 1'b1;
                    load_full = 1'b1;
                end
            end
            S_STOP: begin
                if (!tick) cnt_dec = 1'b1;
                else if (rxs) push_req = 1'b1;
                else ferr_set = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            baud_cnt <= 16'd0;
            bit_idx  <= 3'd0;
            shreg    <= 8'd0;
        end else begin
            if (load_half)      baud_cnt <= HALF_DIV;
            else if (load_full) baud_cnt <= CLOCK_DIV - 16'd1;
            else if (cnt_dec)   baud_cnt <= baud_cnt - 16'd1;
            if (clr_idx)        bit_idx <= 3'd0;
            else if (shift_en)  bit_idx <= bit_idx + 3'd1;
            if (shift_en)       shreg <= {rxs, shreg[7:1]};
        end
    end

    assign csr_hit    = (addr == BASE_ADDR);
    assign csr_wr     = csr_hit && (modify == 3'b001);
    assign pop_req    = csr_wr && wdata[0];
    assign flush      = csr_wr && wdata[1];
    assign fifo_empty = (count == '0);
    assign pop_ok     = pop_req && !fifo_empty;
    // A pop in the same cycle frees the slot the incoming byte needs
    assign push_ok    = push_req && ((count < DEPTH_CNT) || pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovr  <= 1'b0;
            ferr <= 1'b0;
        end else begin
            if (push_req && !push_ok && !flush) ovr <= 1'b1;
            else if (csr_wr && wdata[9])        ovr <= 1'b0;
            if (ferr_set)                       ferr <= 1'b1;
            else if (csr_wr && wdata[10])       ferr <= 1'b0;
        end
    end

    always_comb begin
        rd_word                     = 32'd0;
        rd_word[7:0]                = fifo_empty ? 8'd0 : mem[rd_ptr];
        rd_word[8]                  = fifo_empty;
        rd_word[9]                  = ovr;
        rd_word[10]                 = ferr;
        rd_word[16 +: DEPTH_LOG2+1] = count;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= 32'd0;
            valid <= 1'b0;
            irq   <= 1'b0;
        end else begin
            rdata <= csr_hit ? rd_word : 32'd0;
            valid <= csr_hit;
            irq   <= !fifo_empty;
        end
    end

endmodule
